stlb_miss_arbiter: RTL and testbench
====================================

# stlb_miss_arbiter

Sequencer and arbiter for the single-ported shared TLB in the MMU: it accepts miss requests from the instruction TLB and the data TLB and serialises them into one shared-TLB lookup at a time. On a shared-TLB miss it launches a page-table walk and returns the result to the requester that issued the miss. It sits between the ITLB/DTLB miss paths and the shared TLB and PTW, and it keeps one transaction in flight.

## Interface
Parameters:
- VADDR_W, 32, virtual address width (Sv32).
- ASID_W, 9, address-space identifier width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- itlb_req_i  in  1  ITLB miss request (level, held until granted).
- itlb_vaddr_i  in  VADDR_W  ITLB miss virtual address.
- itlb_gnt_o  out  1  one-cycle pulse; ITLB request accepted.
- itlb_rsp_valid_o  out  1  one-cycle pulse; ITLB result valid.
- dtlb_req_i / dtlb_vaddr_i / dtlb_gnt_o / dtlb_rsp_valid_o  same as the ITLB ports, for the DTLB.
- rsp_hit_o  out  1  the translation exists; qualified by either rsp_valid.
- rsp_err_o  out  1  the walk faulted; qualified by either rsp_valid.
- asid_i  in  ASID_W  current ASID; sampled at grant.
- lu_req_o  out  1  shared-TLB lookup strobe (one cycle).
- lu_vaddr_o  out  VADDR_W  lookup address.
- lu_asid_o  out  ASID_W  lookup ASID.
- lu_valid_i  in  1  lookup result valid.
- lu_hit_i  in  1  lookup hit.
- ptw_req_o  out  1  walk request; held until accepted.
- ptw_vaddr_o  out  VADDR_W  walk address.
- ptw_is_instr_o  out  1  walk originates from the ITLB.
- ptw_busy_i  in  1  PTW cannot accept a request this cycle.
- ptw_done_i  in  1  walk complete (one-cycle pulse).
- ptw_err_i  in  1  walk fault; qualified by ptw_done_i.
- flush_i  in  1  sfence.vma flush.
- busy_o  out  1  the FSM is not in IDLE.

## Operation
FSM states:
- IDLE.
  - If one or more requests are pending, select a winner.
  - Pulse the winner's gnt.
  - Capture the winner's vaddr, asid_i and source into registers.
  - Pulse lu_req_o in the same cycle.
  - Go to LOOKUP.
- LOOKUP: wait for lu_valid_i.
  - lu_hit_i=1: go to RESPOND with hit=1, err=0.
  - lu_hit_i=0: go to WALK_REQ.
- WALK_REQ: assert ptw_req_o. When ptw_busy_i=0 in that cycle, go to WALK_WAIT.
- WALK_WAIT: on ptw_done_i, go to RESPOND with hit=!ptw_err_i and err=ptw_err_i.
- RESPOND:
  - Pulse the captured source's rsp_valid.
  - Drive rsp_hit_o and rsp_err_o from registers.
  - Go to IDLE.

Flush rules:
- flush_i in LOOKUP or WALK_REQ: go to IDLE next cycle. No response is produced, and no PTW request is issued after the flush cycle.
- flush_i in WALK_WAIT: set a drop flag. Stay in WALK_WAIT until ptw_done_i, then go to IDLE without a response. A walk is never abandoned mid-flight.
- flush_i in IDLE: no grant is issued in that cycle.
- flush_i in RESPOND: the response is still delivered.

Other rules:
- lu_valid_i is ignored outside LOOKUP; ptw_done_i is ignored outside WALK_WAIT.
- rsp_hit_o and rsp_err_o hold their last value between responses.
- The requester must keep req_i asserted until gnt; the arbiter does not check this.
- Address registers are VADDR_W bits wide and are passed through unmodified.

## Timing
- Reset values:
  - FSM in IDLE; round-robin pointer favours DTLB; drop flag cleared.
  - All gnt, rsp_valid, lu_req_o, ptw_req_o and busy_o are 0.
  - rsp_hit_o, rsp_err_o, ptw_is_instr_o, lu_vaddr_o, lu_asid_o and ptw_vaddr_o are 0.
- Grant and lu_req_o: 0 cycles from the request being seen in IDLE, registered-state Mealy output.
- Hit latency: grant cycle G, lu_valid_i at G+1, rsp_valid at G+2.
- Miss latency: ptw_req_o first at G+2; rsp_valid one cycle after ptw_done_i.
- Back-to-back: a new grant is possible in the cycle after RESPOND, so throughput is at most one transaction per 3 cycles.
- Reset asserted mid-transaction: immediate return to the reset state; outstanding responses are lost.

## Configuration
- STLB_ARB_RR_EN defined: round-robin arbitration.
  - The pointer toggles to the non-winner after each grant.
  - On a tie, the side the pointer favours wins.
- STLB_ARB_RR_EN undefined: fixed priority.
  - DTLB always wins ties; the pointer logic is removed.
  - ITLB can be starved by continuous DTLB requests.

## Test plan
- DTLB hit, vaddr=0x8000_1000:
  - dtlb_gnt_o pulses at cycle 0 and lu_vaddr_o=0x8000_1000.
  - lu_hit_i=1 at cycle 1.
  - dtlb_rsp_valid_o=1 with rsp_hit_o=1 at cycle 2; ITLB outputs stay 0.
- ITLB miss to walk:
  - lu_hit_i=0; ptw_req_o holds for 3 cycles of ptw_busy_i=1, with ptw_is_instr_o=1.
  - ptw_done_i with ptw_err_i=1 gives itlb_rsp_valid_o=1, rsp_hit_o=0, rsp_err_o=1.
- Simultaneous ITLB and DTLB requests from reset:
  - With RR: DTLB is granted first, ITLB second, DTLB third.
  - Without RR: DTLB takes every grant while dtlb_req_i is held.
- flush_i in WALK_WAIT:
  - No rsp_valid is produced.
  - busy_o stays 1 until ptw_done_i, then falls.
  - The next request is granted normally.
- flush_i in LOOKUP: FSM is in IDLE next cycle, a late lu_valid_i is ignored, and no ptw_req_o is issued.
- rst_i asserted in WALK_WAIT: all outputs are 0 in the same cycle, without waiting for a clock edge; the FSM is in IDLE after release.

Source files
------------

// File: rtl/stlb_miss_arbiter.sv
// stlb_miss_arbiter
// -----------------
// Serialises ITLB and DTLB miss requests onto the single-ported shared TLB.
// Only one transaction is in flight at a time. A shared-TLB miss launches a
// page-table walk. The result goes back to whichever side issued the miss.
//
// Optional feature macro:
//   STLB_ARB_RR_EN  defined   -> round-robin arbitration between ITLB/DTLB
//                   undefined -> fixed priority, DTLB wins every tie
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   itlb_req_i / itlb_vaddr_i       ITLB miss request (level) and address
//   itlb_gnt_o / itlb_rsp_valid_o   ITLB grant pulse / response pulse
//   dtlb_*                          same set for the DTLB
//   rsp_hit_o / rsp_err_o           response status, held between responses
//   asid_i                          current ASID, captured at grant
//   lu_req_o/lu_vaddr_o/lu_asid_o   shared-TLB lookup strobe and operands
//   lu_valid_i / lu_hit_i           shared-TLB lookup result
//   ptw_req_o/ptw_vaddr_o/
//   ptw_is_instr_o                  page-table walk request
//   ptw_busy_i                      PTW cannot accept this cycle
//   ptw_done_i / ptw_err_i          walk completion pulse and fault flag
//   flush_i                         sfence.vma flush
//   busy_o                          a transaction is in progress
module stlb_miss_arbiter #(
  parameter int VADDR_W = 32,
  parameter int ASID_W  = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               itlb_req_i,
  input  logic [VADDR_W-1:0] itlb_vaddr_i,
  output logic               itlb_gnt_o,
  output logic               itlb_rsp_valid_o,
  input  logic               dtlb_req_i,
  input  logic [VADDR_W-1:0] dtlb_vaddr_i,
  output logic               dtlb_gnt_o,
  output logic               dtlb_rsp_valid_o,
  output logic               rsp_hit_o,
  output logic               rsp_err_o,
  input  logic [ASID_W-1:0]  asid_i,
  output logic               lu_req_o,
  output logic [VADDR_W-1:0] lu_vaddr_o,
  output logic [ASID_W-1:0]  lu_asid_o,
  input  logic               lu_valid_i,
  input  logic               lu_hit_i,
  output logic               ptw_req_o,
  output logic [VADDR_W-1:0] ptw_vaddr_o,
  output logic               ptw_is_instr_o,
  input  logic               ptw_busy_i,
  input  logic               ptw_done_i,
  input  logic               ptw_err_i,
  input  logic               flush_i,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WALK_REQ  = 3'd2,
    S_WALK_WAIT = 3'd3,
    S_RESPOND   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [VADDR_W-1:0] vaddr_q, vaddr_d;
  logic [ASID_W-1:0]  asid_q, asid_d;
  logic               src_instr_q, src_instr_d;   // 1: ITLB owns the transaction
  logic               hit_q, hit_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;             // flushed while a walk is in flight

  logic               grant_en;
  logic               pick_itlb;
  logic [VADDR_W-1:0] win_vaddr;

`ifdef STLB_ARB_RR_EN
  logic               prio_itlb_q, prio_itlb_d;   // 1: ITLB wins the next tie

  always_comb begin
    pick_itlb = itlb_req_i && (!dtlb_req_i || prio_itlb_q);
  end
`else
  always_comb begin
    pick_itlb = itlb_req_i && !dtlb_req_i;
  end
`endif

  // Grant is a Mealy output of the registered IDLE state. It is also gated
  // by rst_i so that every output reads 0 while reset is asserted.
  always_comb begin
    grant_en  = (state_q == S_IDLE) && (itlb_req_i || dtlb_req_i) && !flush_i && !rst_i;
    win_vaddr = pick_itlb ? itlb_vaddr_i : dtlb_vaddr_i;
  end

  always_comb begin
    itlb_gnt_o       = grant_en && pick_itlb;
    dtlb_gnt_o       = grant_en && !pick_itlb;
    lu_req_o         = grant_en;
    // The lookup operands come straight from the winner in the grant cycle.
    // After that, the captured copy is held for the rest of the transaction.
    lu_vaddr_o       = grant_en ? win_vaddr : vaddr_q;
    lu_asid_o        = grant_en ? asid_i : asid_q;
    // The request is withdrawn in a flush cycle so that a flushed walk is
    // never accepted by the PTW on the way out.
    ptw_req_o        = (state_q == S_WALK_REQ) && !flush_i;
    ptw_vaddr_o      = vaddr_q;
    ptw_is_instr_o   = src_instr_q;
    itlb_rsp_valid_o = (state_q == S_RESPOND) && src_instr_q;
    dtlb_rsp_valid_o = (state_q == S_RESPOND) && !src_instr_q;
    rsp_hit_o        = hit_q;
    rsp_err_o        = err_q;
    busy_o           = (state_q != S_IDLE);
  end

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    asid_d      = asid_q;
    src_instr_d = src_instr_q;
    hit_d       = hit_q;
    err_d       = err_q;
    drop_d      = drop_q;
`ifdef STLB_ARB_RR_EN
    prio_itlb_d = prio_itlb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          vaddr_d     = win_vaddr;
          asid_d      = asid_i;
          src_instr_d = pick_itlb;
          state_d     = S_LOOKUP;
`ifdef STLB_ARB_RR_EN
          // The pointer moves to the side that did not win this grant.
          prio_itlb_d = !pick_itlb;
`endif
        end
      end
      S_LOOKUP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (lu_valid_i) begin
          if (lu_hit_i) begin
            hit_d   = 1'b1;
            err_d   = 1'b0;
            state_d = S_RESPOND;
          end else begin
            state_d = S_WALK_REQ;
          end
        end
      end
      S_WALK_REQ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!ptw_busy_i) begin
          state_d = S_WALK_WAIT;
        end
      end
      S_WALK_WAIT: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (ptw_done_i) begin
          drop_d = 1'b0;
          // A flush arriving in the same cycle as done also drops the result.
          if (drop_q || flush_i) begin
            state_d = S_IDLE;
          end else begin
            hit_d   = !ptw_err_i;
            err_d   = ptw_err_i;
            state_d = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      vaddr_q     <= '0;
      asid_q      <= '0;
      src_instr_q <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
`ifdef STLB_ARB_RR_EN
      prio_itlb_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      asid_q      <= asid_d;
      src_instr_q <= src_instr_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
`ifdef STLB_ARB_RR_EN
      prio_itlb_q <= prio_itlb_d;
`endif
    end
  end

endmodule

// File: tb/tb_stlb_miss_arbiter.sv
// tb_stlb_miss_arbiter
// Transaction-level bench for stlb_miss_arbiter. Each transaction is described
// by its requesters, lookup outcome, PTW behaviour and flush point. A small
// reference model predicts the winner, the response and the held status.
module tb_stlb_miss_arbiter;

  localparam int VADDR_W = 32;
  localparam int ASID_W  = 9;

  logic               clk_i;
  logic               rst_i;
  logic               itlb_req_i, dtlb_req_i;
  logic [VADDR_W-1:0] itlb_vaddr_i, dtlb_vaddr_i;
  logic               itlb_gnt_o, dtlb_gnt_o;
  logic               itlb_rsp_valid_o, dtlb_rsp_valid_o;
  logic               rsp_hit_o, rsp_err_o;
  logic [ASID_W-1:0]  asid_i;
  logic               lu_req_o;
  logic [VADDR_W-1:0] lu_vaddr_o;
  logic [ASID_W-1:0]  lu_asid_o;
  logic               lu_valid_i, lu_hit_i;
  logic               ptw_req_o;
  logic [VADDR_W-1:0] ptw_vaddr_o;
  logic               ptw_is_instr_o;
  logic               ptw_busy_i, ptw_done_i, ptw_err_i;
  logic               flush_i;
  logic               busy_o;

  stlb_miss_arbiter #(.VADDR_W(VADDR_W), .ASID_W(ASID_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i),
    .itlb_gnt_o(itlb_gnt_o), .itlb_rsp_valid_o(itlb_rsp_valid_o),
    .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_gnt_o(dtlb_gnt_o), .dtlb_rsp_valid_o(dtlb_rsp_valid_o),
    .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o),
    .asid_i(asid_i),
    .lu_req_o(lu_req_o), .lu_vaddr_o(lu_vaddr_o), .lu_asid_o(lu_asid_o),
    .lu_valid_i(lu_valid_i), .lu_hit_i(lu_hit_i),
    .ptw_req_o(ptw_req_o), .ptw_vaddr_o(ptw_vaddr_o), .ptw_is_instr_o(ptw_is_instr_o),
    .ptw_busy_i(ptw_busy_i), .ptw_done_i(ptw_done_i), .ptw_err_i(ptw_err_i),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model state
  bit m_prio_itlb;   // which side wins the next tie under round-robin
  bit m_hit, m_err;  // last delivered response status

  localparam int F_NONE = 0, F_IDLE = 1, F_LOOKUP = 2, F_WALKREQ = 3, F_WALKWAIT = 4, F_RESPOND = 5;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_rsp_quiet(input string tag);
    check_eq({tag, "_irsp"}, 64'(itlb_rsp_valid_o), 64'(0));
    check_eq({tag, "_drsp"}, 64'(dtlb_rsp_valid_o), 64'(0));
    check_eq({tag, "_hit_hold"}, 64'(rsp_hit_o), 64'(m_hit));
    check_eq({tag, "_err_hold"}, 64'(rsp_err_o), 64'(m_err));
  endtask

  // Predicted winner for the given request pattern.
  function automatic bit model_pick_itlb(input bit ri, input bit rd);
    if (ri && !rd) return 1'b1;
    if (rd && !ri) return 1'b0;
`ifdef STLB_ARB_RR_EN
    return m_prio_itlb;
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction. Entered and left at posedge+1 with the DUT in IDLE.
  task automatic txn(input bit ri, input bit rd,
                     input logic [VADDR_W-1:0] vi, input logic [VADDR_W-1:0] vd,
                     input logic [ASID_W-1:0] asid, input bit hit,
                     input int lu_delay, input int busy_n, input int wait_n,
                     input bit err, input int fmode);
    bit win_i;
    logic [VADDR_W-1:0] wv;
    bit exp_hit, exp_err;
    bit dropped;
    n_txn++;
    itlb_req_i = ri; dtlb_req_i = rd;
    itlb_vaddr_i = vi; dtlb_vaddr_i = vd; asid_i = asid;
    if (fmode == F_IDLE) begin
      flush_i = 1'b1;
      #1;
      check_eq("flush_idle_ignt", 64'(itlb_gnt_o), 64'(0));
      check_eq("flush_idle_dgnt", 64'(dtlb_gnt_o), 64'(0));
      check_eq("flush_idle_lureq", 64'(lu_req_o), 64'(0));
      next_cycle();
      flush_i = 1'b0;
    end
    win_i = model_pick_itlb(ri, rd);
    wv = win_i ? vi : vd;
    #1;
    check_eq("gnt_itlb", 64'(itlb_gnt_o), 64'(win_i));
    check_eq("gnt_dtlb", 64'(dtlb_gnt_o), 64'(!win_i));
    check_eq("lu_req", 64'(lu_req_o), 64'(1));
    check_eq("lu_vaddr", 64'(lu_vaddr_o), 64'(wv));
    check_eq("lu_asid", 64'(lu_asid_o), 64'(asid));
    check_eq("busy_idle", 64'(busy_o), 64'(0));
    check_rsp_quiet("grant");
    m_prio_itlb = !win_i;
    next_cycle();
    // Scramble inputs so only captured values can appear on the outputs.
    itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    itlb_vaddr_i = $urandom; dtlb_vaddr_i = $urandom; asid_i = ASID_W'($urandom);

    if (fmode == F_LOOKUP) begin
      flush_i = 1'b1;
      #1;
      check_eq("flu_busy", 64'(busy_o), 64'(1));
      next_cycle();
      flush_i = 1'b0; lu_valid_i = 1'b1; lu_hit_i = 1'b0;
      #1;
      check_eq("flu_idle", 64'(busy_o), 64'(0));
      check_eq("flu_ptw0", 64'(ptw_req_o), 64'(0));
      check_rsp_quiet("flu");
      next_cycle();
      lu_valid_i = 1'b0;
      #1;
      check_eq("flu_ptw1", 64'(ptw_req_o), 64'(0));
      check_eq("flu_busy1", 64'(busy_o), 64'(0));
      next_cycle();
      $display("txn %0d src=%s vaddr=%h flushed_in_lookup", n_txn, win_i ? "I" : "D", wv);
      return;
    end

    for (int i = 0; i < lu_delay; i++) begin
      #1;
      check_eq("lu_wait_busy", 64'(busy_o), 64'(1));
      check_eq("lu_wait_lureq", 64'(lu_req_o), 64'(0));
      next_cycle();
    end
    lu_valid_i = 1'b1; lu_hit_i = hit;
    #1;
    check_eq("lu_vaddr_hold", 64'(lu_vaddr_o), 64'(wv));
    check_eq("lu_busy", 64'(busy_o), 64'(1));
    next_cycle();
    lu_valid_i = 1'b0; lu_hit_i = 1'b0;
    dropped = 1'b0;
    exp_hit = 1'b1; exp_err = 1'b0;

    if (!hit) begin
      if (fmode == F_WALKREQ) begin
        ptw_busy_i = 1'b1;
        #1;
        check_eq("fwr_ptwreq", 64'(ptw_req_o), 64'(1));
        next_cycle();
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0; ptw_busy_i = 1'b0;
        #1;
        check_eq("fwr_idle", 64'(busy_o), 64'(0));
        check_eq("fwr_ptw0", 64'(ptw_req_o), 64'(0));
        check_rsp_quiet("fwr");
        next_cycle();
        $display("txn %0d src=%s vaddr=%h flushed_in_walk_req", n_txn, win_i ? "I" : "D", wv);
        return;
      end
      for (int i = 0; i < busy_n; i++) begin
        ptw_busy_i = 1'b1;
        #1;
        check_eq("ptw_req_held", 64'(ptw_req_o), 64'(1));
        check_eq("ptw_vaddr", 64'(ptw_vaddr_o), 64'(wv));
        check_eq("ptw_is_instr", 64'(ptw_is_instr_o), 64'(win_i));
        next_cycle();
      end
      ptw_busy_i = 1'b0;
      #1;
      check_eq("ptw_req_acc", 64'(ptw_req_o), 64'(1));
      check_eq("ptw_vaddr_acc", 64'(ptw_vaddr_o), 64'(wv));
      next_cycle();
      for (int i = 0; i < wait_n; i++) begin
        if (fmode == F_WALKWAIT && i == 0) flush_i = 1'b1;
        #1;
        check_eq("ww_ptw0", 64'(ptw_req_o), 64'(0));
        check_eq("ww_busy", 64'(busy_o), 64'(1));
        check_rsp_quiet("ww");
        next_cycle();
        flush_i = 1'b0;
      end
      ptw_done_i = 1'b1; ptw_err_i = err;
      if (fmode == F_WALKWAIT && wait_n == 0) flush_i = 1'b1;
      #1;
      check_eq("done_busy", 64'(busy_o), 64'(1));
      next_cycle();
      ptw_done_i = 1'b0; ptw_err_i = 1'b0; flush_i = 1'b0;
      dropped = (fmode == F_WALKWAIT);
      exp_hit = !err; exp_err = err;
    end

    if (dropped) begin
      #1;
      check_eq("drop_idle", 64'(busy_o), 64'(0));
      check_rsp_quiet("drop");
    end else begin
      if (fmode == F_RESPOND) flush_i = 1'b1;
      #1;
      check_eq("rsp_itlb", 64'(itlb_rsp_valid_o), 64'(win_i));
      check_eq("rsp_dtlb", 64'(dtlb_rsp_valid_o), 64'(!win_i));
      check_eq("rsp_hit", 64'(rsp_hit_o), 64'(exp_hit));
      check_eq("rsp_err", 64'(rsp_err_o), 64'(exp_err));
      m_hit = exp_hit; m_err = exp_err;
      next_cycle();
      flush_i = 1'b0;
    end
    $display("txn %0d src=%s vaddr=%h hit=%0d err=%0d dropped=%0d flush=%0d",
             n_txn, win_i ? "I" : "D", wv, exp_hit, exp_err, dropped, fmode);
  endtask

  initial begin
    rst_i = 1'b1;
    itlb_req_i = 0; dtlb_req_i = 0; itlb_vaddr_i = '0; dtlb_vaddr_i = '0;
    asid_i = '0; lu_valid_i = 0; lu_hit_i = 0;
    ptw_busy_i = 0; ptw_done_i = 0; ptw_err_i = 0; flush_i = 0;
    m_prio_itlb = 1'b0; m_hit = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_busy", 64'(busy_o), 64'(0));
    check_eq("rst_lu_vaddr", 64'(lu_vaddr_o), 64'(0));
    check_eq("rst_ptw_req", 64'(ptw_req_o), 64'(0));
    check_eq("rst_hit", 64'(rsp_hit_o), 64'(0));
    rst_i = 1'b0;
    next_cycle();

    // Simultaneous requests straight out of reset.
    for (int k = 0; k < 3; k++)
      txn(1, 1, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 9'h011, 1, 0, 0, 0, 0, F_NONE);
    // DTLB hit.
    txn(0, 1, 32'h0, 32'h8000_1000, 9'h05a, 1, 0, 0, 0, 0, F_NONE);
    // ITLB miss, PTW busy for 3 cycles, walk faults.
    txn(1, 0, 32'h0040_2000, 32'h0, 9'h1ff, 0, 0, 3, 2, 1, F_NONE);
    // Flush during the walk, then a normal request.
    txn(0, 1, 32'h0, 32'h7777_0000, 9'h003, 0, 0, 1, 2, 0, F_WALKWAIT);
    txn(1, 0, 32'h0abc_d000, 32'h0, 9'h004, 1, 0, 0, 0, 0, F_NONE);
    // Flush during lookup.
    txn(0, 1, 32'h0, 32'h5555_5000, 9'h006, 0, 0, 0, 0, 0, F_LOOKUP);

    // Reset during WALK_WAIT.
    dtlb_req_i = 1'b1; dtlb_vaddr_i = 32'h1234_5000; asid_i = 9'h0aa;
    #1;
    check_eq("rw_gnt", 64'(lu_req_o), 64'(1));
    next_cycle();
    dtlb_req_i = 1'b0; lu_valid_i = 1'b1; lu_hit_i = 1'b0;
    next_cycle();
    lu_valid_i = 1'b0; ptw_busy_i = 1'b0;
    next_cycle();
    itlb_req_i = 1'b1; dtlb_req_i = 1'b1;
    #1;
    check_eq("rw_busy_pre", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    check_eq("rw_ignt", 64'(itlb_gnt_o), 64'(0));
    check_eq("rw_dgnt", 64'(dtlb_gnt_o), 64'(0));
    check_eq("rw_irsp", 64'(itlb_rsp_valid_o), 64'(0));
    check_eq("rw_drsp", 64'(dtlb_rsp_valid_o), 64'(0));
    check_eq("rw_hit", 64'(rsp_hit_o), 64'(0));
    check_eq("rw_err", 64'(rsp_err_o), 64'(0));
    check_eq("rw_lureq", 64'(lu_req_o), 64'(0));
    check_eq("rw_luvaddr", 64'(lu_vaddr_o), 64'(0));
    check_eq("rw_luasid", 64'(lu_asid_o), 64'(0));
    check_eq("rw_ptwreq", 64'(ptw_req_o), 64'(0));
    check_eq("rw_ptwvaddr", 64'(ptw_vaddr_o), 64'(0));
    check_eq("rw_ptwinstr", 64'(ptw_is_instr_o), 64'(0));
    check_eq("rw_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
    m_prio_itlb = 1'b0; m_hit = 1'b0; m_err = 1'b0;
    ptw_done_i = 1'b1;
    #1;
    check_eq("rw_after_busy", 64'(busy_o), 64'(0));
    check_rsp_quiet("rw_after");
    next_cycle();
    ptw_done_i = 1'b0;
    txn(1, 1, 32'hc000_0000, 32'hd000_0000, 9'h001, 1, 0, 0, 0, 0, F_NONE);

    // Randomized transactions.
    for (int k = 0; k < 150; k++) begin
      bit ri, rd, hit, err;
      int fmode;
      ri = 1'($urandom);
      rd = 1'($urandom);
      if (!ri && !rd) rd = 1'b1;
      hit = 1'($urandom);
      err = 1'($urandom);
      fmode = ($urandom_range(0, 9) < 5) ? F_NONE : int'($urandom_range(1, 5));
      if (fmode == F_WALKREQ || fmode == F_WALKWAIT) hit = 1'b0;
      txn(ri, rd, $urandom, $urandom, ASID_W'($urandom), hit,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), err, fmode);
    end

    #1;
    check_eq("final_idle", 64'(busy_o), 64'(0));
    check_rsp_quiet("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
